reg_cmd_arbiter: RTL and testbench

Arbitrates up to four register-access requesters (for example the configuration sequencer, a debug port and a self-test engine) onto the single register command bus (`cmd` / `cmd_addr` / `cmd_data_m2s` / `cmd_data_s2m`). It sits between the requesters and the register slave. It serialises one transaction at a time, drives the bus for exactly one cycle per access, captures read data, and returns a one-cycle acknowledge to the granted requester.

---
 rtl/reg_cmd_arbiter.sv | 154 +++++++++++++++
 tb/tb_reg_cmd_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_cmd_arbiter
// Description : Serialises up to four register requesters onto one register
//               command bus. Round-robin by default; define
//               REG_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cmd_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [2*NUM_REQ-1:0]  req_cmd,
    input  logic [8*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic [31:0]           rdata,
    output logic [1:0]            cmd,
    output logic [7:0]            cmd_addr,
    output logic [31:0]           cmd_data_m2s,
    input  logic [31:0]           cmd_data_s2m
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_cmd_idle    = 2'b00;
    localparam logic [1:0] c_cmd_read    = 2'b01;
    localparam logic [1:0] c_cmd_illegal = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_win;
    logic [1:0]         r_cmd;
`ifndef REG_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]   r_ptr;
    int                 w_idx;
`endif

    logic [NUM_REQ-1:0] w_elig;
    logic               w_any;
    logic [PTR_W-1:0]   w_win;
    logic [1:0]         w_win_cmd;
    logic [7:0]         w_win_addr;
    logic [31:0]        w_win_wdata;
    logic [NUM_REQ-1:0] w_grant_vec;
    logic [NUM_REQ-1:0] w_ack_vec;

    always_comb begin
        w_elig = '0;
        w_any  = 1'b0;
        w_win  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req[i] && (req_cmd[2*i +: 2] != c_cmd_idle);
        end
`ifdef REG_ARB_FIXED_PRIO_EN
        // Descending scan: the lowest eligible index is assigned last and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any = 1'b1;
                w_win = PTR_W'(i);
            end
        end
`else
        // Descending offset scan: the requester closest to ptr is assigned last.
        w_idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = PTR_W'(w_idx);
            end
        end
`endif
        w_win_cmd   = req_cmd[2*w_win +: 2];
        w_win_addr  = req_addr[8*w_win +: 8];
        w_win_wdata = req_wdata[32*w_win +: 32];
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_vec[i] = (w_win == PTR_W'(i));
            w_ack_vec[i]   = (r_win == PTR_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_win        <= '0;
            r_cmd        <= c_cmd_idle;
`ifndef REG_ARB_FIXED_PRIO_EN
            r_ptr        <= '0;
`endif
            ack          <= '0;
            rdata        <= '0;
            cmd          <= c_cmd_idle;
            cmd_addr     <= '0;
            cmd_data_m2s <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win <= w_win;
                        r_cmd <= w_win_cmd;
`ifndef REG_ARB_FIXED_PRIO_EN
                        r_ptr <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
`endif
                        if (w_win_cmd == c_cmd_illegal) begin
                            r_state <= ST_ACK;
                            ack     <= w_grant_vec;
                            rdata   <= '0;
                        end else begin
                            r_state      <= ST_ISSUE;
                            cmd          <= w_win_cmd;
                            cmd_addr     <= w_win_addr;
                            cmd_data_m2s <= w_win_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    cmd          <= c_cmd_idle;
                    cmd_addr     <= '0;
                    cmd_data_m2s <= '0;
                    if (r_cmd == c_cmd_read) begin
                        r_state <= ST_RD_WAIT;
                    end else begin
                        r_state <= ST_ACK;
                        ack     <= w_ack_vec;
                        rdata   <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    r_state <= ST_ACK;
                    ack     <= w_ack_vec;
                    rdata   <= cmd_data_s2m;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    ack     <= '0;
                    rdata   <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_cmd_arbiter
// Description : Directed self-checking bench for reg_cmd_arbiter, NUM_REQ = 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_cmd_arbiter;

    localparam int NUM_REQ = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [2*NUM_REQ-1:0]  req_cmd = '0;
    logic [8*NUM_REQ-1:0]  req_addr = '0;
    logic [32*NUM_REQ-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]    ack;
    logic [31:0]           rdata;
    logic [1:0]            cmd;
    logic [7:0]            cmd_addr;
    logic [31:0]           cmd_data_m2s;
    logic [31:0]           cmd_data_s2m = '0;

    int n_checks = 0;
    int n_errors = 0;

    reg_cmd_arbiter #(.NUM_REQ(NUM_REQ)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .rdata        (rdata),
        .cmd          (cmd),
        .cmd_addr     (cmd_addr),
        .cmd_data_m2s (cmd_data_m2s),
        .cmd_data_s2m (cmd_data_s2m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic on, input logic [1:0] c,
                           input logic [7:0] a, input logic [31:0] d);
        req[i]             = on;
        req_cmd[2*i +: 2]  = c;
        req_addr[8*i +: 8] = a;
        req_wdata[32*i +: 32] = d;
    endtask

    int exp_order [6];
    int grants;
    logic prev_bus;
    logic back_to_back;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_addr", 32'(cmd_addr), 32'h0);
        chk("rst_m2s", cmd_data_m2s, 32'h0);
        rst = 1'b0;
        tick();

        // Single write, requester 0
        set_req(0, 1'b1, 2'b10, 8'h04, 32'hA5A5_0001);
        tick();
        chk("wr_cmd", 32'(cmd), 32'h2);
        chk("wr_addr", 32'(cmd_addr), 32'h04);
        chk("wr_data", cmd_data_m2s, 32'hA5A5_0001);
        chk("wr_noack", 32'(ack), 32'h0);
        tick();
        chk("wr_ack", 32'(ack), 32'h1);
        chk("wr_busidle", 32'(cmd), 32'h0);
        chk("wr_rdata", rdata, 32'h0);
        set_req(0, 1'b0, 2'b00, 8'h00, 32'h0);
        tick();
        chk("wr_ackdrop", 32'(ack), 32'h0);

        // Single read, requester 1
        set_req(1, 1'b1, 2'b01, 8'h10, 32'h0);
        tick();
        chk("rd_cmd", 32'(cmd), 32'h1);
        chk("rd_addr", 32'(cmd_addr), 32'h10);
        tick();
        chk("rd_wait_bus", 32'(cmd), 32'h0);
        chk("rd_wait_ack", 32'(ack), 32'h0);
        cmd_data_s2m = 32'h1234_5678;
        tick();
        chk("rd_ack", 32'(ack), 32'h2);
        chk("rd_rdata", rdata, 32'h1234_5678);
        set_req(1, 1'b0, 2'b00, 8'h00, 32'h0);
        cmd_data_s2m = 32'h0;
        tick();
        chk("rd_ackdrop", 32'(ack), 32'h0);

        // Illegal command, requester 0 (ptr=2, wraps to 0)
        set_req(0, 1'b1, 2'b11, 8'h55, 32'hFFFF_FFFF);
        tick();
        chk("ill_ack", 32'(ack), 32'h1);
        chk("ill_rdata", rdata, 32'h0);
        chk("ill_cmd", 32'(cmd), 32'h0);
        set_req(0, 1'b0, 2'b00, 8'h00, 32'h0);
        tick();
        chk("ill_ackdrop", 32'(ack), 32'h0);
        chk("ill_cmd2", 32'(cmd), 32'h0);

        // Reset during RD_WAIT
        set_req(2, 1'b1, 2'b01, 8'h20, 32'h0);
        tick();
        chk("rst_rd_issue", 32'(cmd), 32'h1);
        tick();
        rst = 1'b1;
        cmd_data_s2m = 32'hDEAD_BEEF;
        tick();
        chk("rstmid_ack", 32'(ack), 32'h0);
        chk("rstmid_rdata", rdata, 32'h0);
        chk("rstmid_cmd", 32'(cmd), 32'h0);
        chk("rstmid_addr", 32'(cmd_addr), 32'h0);
        rst = 1'b0;
        cmd_data_s2m = 32'h0;
        set_req(2, 1'b0, 2'b00, 8'h00, 32'h0);
        tick();
        chk("rstmid_noack", 32'(ack), 32'h0);
        set_req(1, 1'b1, 2'b10, 8'h30, 32'h1111_2222);
        tick();
        chk("post_wr_cmd", 32'(cmd), 32'h2);
        chk("post_wr_addr", 32'(cmd_addr), 32'h30);
        chk("post_wr_data", cmd_data_m2s, 32'h1111_2222);
        tick();
        chk("post_wr_ack", 32'(ack), 32'h2);
        set_req(1, 1'b0, 2'b00, 8'h00, 32'h0);
        tick();

        // Fairness: continuous writes from all requesters starting from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef REG_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 0, 1, 2};
`endif
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 1'b1, 2'b10, 8'(8'h40 + i), 32'(32'hC0DE_0000 + i));
        grants = 0;
        prev_bus = 1'b0;
        back_to_back = 1'b0;
        for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
            tick();
            if (cmd != 2'b00 && prev_bus) back_to_back = 1'b1;
            prev_bus = (cmd != 2'b00);
            if (cmd != 2'b00)
                chk("fair_addr", 32'(cmd_addr), 32'(8'h40 + exp_order[grants]));
            if (ack != '0) begin
                chk("fair_grant", 32'(ack), 32'(3'b001 << exp_order[grants]));
                grants++;
            end
        end
        chk("fair_count", grants, 6);
        chk("fair_no_b2b_bus", 32'(back_to_back), 32'h0);
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
